adsr_envelope: RTL and testbench

ADSR envelope generator for the MiniMoog voice path. It converts a note gate into a 12-bit unsigned amplitude envelope with programmable attack, decay and release rates and a programmable sustain level. It sits directly upstream of the `dsDAC` delta-sigma converters: it drives an output bus, or the VCA multiplier that feeds that bus. All state advances only on a one-cycle `tick` sample-rate enable, so one system clock serves every voice.

---
 rtl/adsr_envelope_if.sv | 30 +++
 rtl/adsr_envelope.sv | 130 +++++++++++++
 tb/tb_adsr_envelope.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_envelope_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adsr_envelope_if : gate/rate controls in, envelope value/stage out    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface adsr_envelope_if #(
   parameter int N      = 12,
   parameter int RATE_W = 16
);
   logic              tick;
   logic              gate;
   logic [RATE_W-1:0] attack_inc;
   logic [RATE_W-1:0] decay_inc;
   logic [N-1:0]      sustain_lvl;
   logic [RATE_W-1:0] release_inc;
   logic [N-1:0]      env;
   logic [2:0]        stage;
   logic              active;

   modport master (
      output tick, gate, attack_inc, decay_inc, sustain_lvl, release_inc,
      input  env, stage, active
   );

   modport slave (
      input  tick, gate, attack_inc, decay_inc, sustain_lvl, release_inc,
      output env, stage, active
   );
endinterface
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adsr_envelope : tick-paced ADSR amplitude envelope generator          |
// | Option macro ADSR_RETRIG_ZERO_EN: every retrigger restarts from zero. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module adsr_envelope #(
   parameter int N      = 12,
   parameter int FRAC   = 8,
   parameter int RATE_W = 16
) (
   input wire             clk,
   input wire             reset,
   adsr_envelope_if.slave bus
);
   localparam int c_ACC_W = N + FRAC;
   localparam int c_EXT_W = c_ACC_W + 1;
   localparam logic [c_EXT_W-1:0] c_MAX_EXT = {1'b0, {c_ACC_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [c_ACC_W-1:0] acc_q, acc_d;
   logic               gate_dly_q, gate_dly_d;
   logic               rise_pend_q, rise_pend_d;
   logic               active_q, active_d;

   logic               w_rise;
   logic [c_ACC_W-1:0] w_base;
   logic [c_EXT_W-1:0] w_att_sum;
   logic               w_att_done;
   logic [c_ACC_W-1:0] w_att_acc;
   logic [c_ACC_W-1:0] w_sus;
   logic [c_EXT_W-1:0] w_dec_lim;
   logic               w_dec_done;
   logic [c_ACC_W-1:0] w_dec_next;
   logic               w_rel_done;
   logic [c_ACC_W-1:0] w_rel_next;
   logic               w_gate_held;

   assign w_rise = bus.gate & ~gate_dly_q;

`ifdef ADSR_RETRIG_ZERO_EN
   assign w_base = rise_pend_q ? '0 : acc_q;
`else
   assign w_base = acc_q;
`endif

   // All comparisons run one bit wider than the accumulator so sums never wrap.
   assign w_att_sum  = c_EXT_W'(w_base) + c_EXT_W'(bus.attack_inc);
   assign w_att_done = (bus.attack_inc == '0) || (w_att_sum >= c_MAX_EXT);
   assign w_att_acc  = w_att_done ? {c_ACC_W{1'b1}} : w_att_sum[c_ACC_W-1:0];

   assign w_sus      = c_ACC_W'(bus.sustain_lvl) << FRAC;
   assign w_dec_lim  = c_EXT_W'(w_sus) + c_EXT_W'(bus.decay_inc);
   assign w_dec_done = (bus.decay_inc == '0) || (c_EXT_W'(acc_q) <= w_dec_lim);
   assign w_dec_next = acc_q - c_ACC_W'(bus.decay_inc);

   assign w_rel_done = (bus.release_inc == '0) ||
                       (c_EXT_W'(acc_q) <= c_EXT_W'(bus.release_inc));
   assign w_rel_next = acc_q - c_ACC_W'(bus.release_inc);

   assign w_gate_held = (state_q == S_ATTACK) || (state_q == S_DECAY) ||
                        (state_q == S_SUSTAIN);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      gate_dly_d  = bus.gate;
      rise_pend_d = w_rise | (rise_pend_q & ~bus.tick);
      if (bus.tick) begin
         // A pending rise enters ATTACK and takes its first step on this tick.
         if (rise_pend_q) begin
            acc_d   = w_att_acc;
            state_d = w_att_done ? S_DECAY : S_ATTACK;
         end else if (!bus.gate && w_gate_held) begin
            state_d = S_RELEASE;
         end else begin
            case (state_q)
               S_IDLE: acc_d = '0;
               S_ATTACK: begin
                  acc_d   = w_att_acc;
                  state_d = w_att_done ? S_DECAY : S_ATTACK;
               end
               S_DECAY: begin
                  acc_d   = w_dec_done ? w_sus : w_dec_next;
                  state_d = w_dec_done ? S_SUSTAIN : S_DECAY;
               end
               S_SUSTAIN: acc_d = w_sus;
               S_RELEASE: begin
                  acc_d   = w_rel_done ? '0 : w_rel_next;
                  state_d = w_rel_done ? S_IDLE : S_RELEASE;
               end
               default: begin
                  acc_d   = '0;
                  state_d = S_IDLE;
               end
            endcase
         end
      end
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         gate_dly_q  <= 1'b0;
         rise_pend_q <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         gate_dly_q  <= gate_dly_d;
         rise_pend_q <= rise_pend_d;
         active_q    <= active_d;
      end
   end

   assign bus.env    = acc_q[c_ACC_W-1:FRAC];
   assign bus.stage  = state_q;
   assign bus.active = active_q;
endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adsr_envelope : directed ADSR scenarios plus random gate/tick run  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_adsr_envelope;
   localparam int N      = 12;
   localparam int FRAC   = 8;
   localparam int RATE_W = 16;
   localparam int MAXV   = (1 << (N + FRAC)) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   adsr_envelope_if #(.N(N), .RATE_W(RATE_W)) bus ();

   adsr_envelope #(.N(N), .FRAC(FRAC), .RATE_W(RATE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference envelope: integer accumulator and stage number straight from the rules.
   int m_acc   = 0;
   int m_stage = 0;
   bit m_pend  = 1'b0;
   bit m_gprev = 1'b0;

   function automatic void m_attack(input int base);
      int sum;
      sum = base + int'(bus.attack_inc);
      if (bus.attack_inc == 0 || sum >= MAXV) begin
         m_acc = MAXV; m_stage = 2;
      end else begin
         m_acc = sum; m_stage = 1;
      end
   endfunction

   always @(posedge clk) begin
      int sus, di, ri;
      bit rise;
      if (!reset) begin
         m_acc = 0; m_stage = 0; m_pend = 1'b0; m_gprev = 1'b0;
      end else begin
         sus  = int'(bus.sustain_lvl) * 256;
         di   = int'(bus.decay_inc);
         ri   = int'(bus.release_inc);
         rise = bus.gate && !m_gprev;
         if (bus.tick) begin
            if (m_pend) begin
`ifdef ADSR_RETRIG_ZERO_EN
               m_attack(0);
`else
               m_attack(m_acc);
`endif
            end else if (!bus.gate && m_stage >= 1 && m_stage <= 3) begin
               m_stage = 4;
            end else if (m_stage == 0) begin
               m_acc = 0;
            end else if (m_stage == 1) begin
               m_attack(m_acc);
            end else if (m_stage == 2) begin
               if (di == 0 || m_acc <= sus + di) begin m_acc = sus; m_stage = 3; end
               else m_acc = m_acc - di;
            end else if (m_stage == 3) begin
               m_acc = sus;
            end else begin
               if (ri == 0 || m_acc <= ri) begin m_acc = 0; m_stage = 0; end
               else m_acc = m_acc - ri;
            end
         end
         m_pend  = rise || (m_pend && !bus.tick);
         m_gprev = bus.gate;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (bus.env !== N'(m_acc >> FRAC) || bus.stage !== 3'(m_stage) ||
             bus.active !== (m_stage != 0)) begin
            fails++;
            $display("FAIL model_cmp t=%0t env=%h want %h stage=%0d want %0d active=%b want %b",
                     $time, bus.env, N'(m_acc >> FRAC), bus.stage, m_stage, bus.active,
                     (m_stage != 0));
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input int env, input int stage, input int act);
      check({name, "_env"},    32'(bus.env),    32'(env));
      check({name, "_stage"},  32'(bus.stage),  32'(stage));
      check({name, "_active"}, 32'(bus.active), 32'(act));
   endtask

   task automatic step_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); bus.tick = 1'b1;
         @(negedge clk); bus.tick = 1'b0;
         repeat (30) @(negedge clk);
      end
   endtask

   function automatic logic [RATE_W-1:0] pick_rate();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return RATE_W'($urandom_range(1, 255));
         default: return RATE_W'($urandom_range(16'h0400, 16'hFFFF));
      endcase
   endfunction

   initial begin
      int retrig_env;
      bus.tick = 1'b0; bus.gate = 1'b0;
      bus.attack_inc = 16'h1000; bus.decay_inc = 16'h0800;
      bus.sustain_lvl = 12'h800; bus.release_inc = 16'h0400;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check_out("reset", 0, 0, 0);
      reset = 1'b1;

      // Attack then decay into sustain
      bus.gate = 1'b1;
      step_ticks(1);   check_out("att_first", 12'h010, 1, 1);
      step_ticks(254); check_out("att_255",   12'hFF0, 1, 1);
      step_ticks(1);   check_out("att_top",   12'hFFF, 2, 1);
      step_ticks(255); check_out("dec_255",   12'h807, 2, 1);
      step_ticks(1);   check_out("dec_sus",   12'h800, 3, 1);

      // Live sustain tracking
      bus.sustain_lvl = 12'h200;
      step_ticks(1);   check_out("sus_live", 12'h200, 3, 1);
      bus.sustain_lvl = 12'h800;
      step_ticks(1);   check_out("sus_back", 12'h800, 3, 1);

      // Release to idle
      bus.gate = 1'b0;
      step_ticks(1);   check_out("rel_enter", 12'h800, 4, 1);
      step_ticks(511); check_out("rel_511",   12'h004, 4, 1);
      step_ticks(1);   check_out("rel_idle",  12'h000, 0, 0);

      // Zero rates and zero sustain
      bus.attack_inc = '0; bus.decay_inc = '0; bus.sustain_lvl = 12'h555;
      bus.gate = 1'b1;
      step_ticks(1);   check_out("zero_att", 12'hFFF, 2, 1);
      step_ticks(1);   check_out("zero_dec", 12'h555, 3, 1);
      bus.sustain_lvl = '0;
      step_ticks(1);   check_out("sus_zero", 12'h000, 3, 1);
      bus.gate = 1'b0; bus.release_inc = '0;
      step_ticks(1);   check_out("zrel_enter", 12'h000, 4, 1);
      step_ticks(1);   check_out("zrel_idle",  12'h000, 0, 0);

      // One-clock gate pulse between ticks
      bus.attack_inc = 16'h1000; bus.release_inc = 16'h0400; bus.sustain_lvl = 12'h800;
      @(negedge clk); bus.gate = 1'b1;
      @(negedge clk); bus.gate = 1'b0;
      step_ticks(1);   check_out("pulse_att", 12'h010, 1, 1);
      step_ticks(1);   check_out("pulse_rel", 12'h010, 4, 1);
      step_ticks(4);   check_out("pulse_idle", 12'h000, 0, 0);

      // Retrigger during release at 0x300
      bus.gate = 1'b1;
      step_ticks(48);  check_out("pre_rt", 12'h300, 1, 1);
      bus.gate = 1'b0;
      step_ticks(1);   check_out("rt_rel", 12'h300, 4, 1);
      bus.gate = 1'b1;
`ifdef ADSR_RETRIG_ZERO_EN
      retrig_env = 12'h010;
`else
      retrig_env = 12'h310;
`endif
      step_ticks(1);   check_out("retrig", retrig_env, 1, 1);

      // Reset with tick high while a rise is pending; the pending rise must be lost
      @(negedge clk); bus.gate = 1'b0;
      @(negedge clk); bus.gate = 1'b1;
      @(negedge clk); reset = 1'b0; bus.tick = 1'b1; bus.gate = 1'b0;
      @(negedge clk); reset = 1'b1; bus.tick = 1'b0;
      check_out("rst_mid", 0, 0, 0);
      step_ticks(2);   check_out("rst_nopend", 0, 0, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         bus.tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) bus.gate = ~bus.gate;
         if ($urandom_range(0, 99) == 0) begin
            bus.attack_inc  = pick_rate();
            bus.decay_inc   = pick_rate();
            bus.release_inc = pick_rate();
            case ($urandom_range(0, 3))
               0:       bus.sustain_lvl = '0;
               1:       bus.sustain_lvl = '1;
               default: bus.sustain_lvl = N'($urandom);
            endcase
         end
         reset = ($urandom_range(0, 799) != 0);
      end
      @(negedge clk); reset = 1'b1; bus.tick = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
